// File: rtl/srff_sched_pkg.sv
// ---------------------------------------------------------------------------
// srff_sched_pkg
//   Shared definitions for the SR-bank scheduler: command op codes and the
//   two-state scheduler FSM encoding.
// ---------------------------------------------------------------------------
package srff_sched_pkg;

  // Command op codes carried on req_op
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Scheduler states: IDLE arbitrates, APPLY drives the bank for one cycle
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/srff_bank_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
//   Purely combinational round-robin picker. Starting at ptr_i and wrapping
//   modulo N, the first asserted request wins.
// Ports:
//   req_i    in   N    request vector
//   ptr_i    in   IW   index with highest priority this cycle
//   grant_o  out  N    one-hot winner (all zero when no request)
//   idx_o    out  IW   binary index of the winner (0 when no request)
//   any_o    out  1    at least one request present
// ---------------------------------------------------------------------------
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          cand;
  logic [IW-1:0] candIdx;

  // Walk the candidates in rotated priority order; the first hit is latched
  // through any_o so later candidates cannot overwrite it.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < N; k++) begin
      cand    = (int'(ptr_i) + k) % N;
      candIdx = IW'(cand);
      if (!any_o && req_i[candIdx]) begin
        any_o            = 1'b1;
        grant_o[candIdx] = 1'b1;
        idx_o            = candIdx;
      end
    end
  end

endmodule

// File: rtl/srff_bank_sched.sv
// ---------------------------------------------------------------------------
// srff_bank_sched
//   Round-robin scheduler sharing one WIDTH-bit bank of T-flip-flop SR cells
//   among NREQ requesters. A granted command is latched in IDLE, applied to
//   the bank in a single APPLY cycle, and signalled by a done pulse one cycle
//   later. SET/RESET are converted to T inputs so the bank never sees s=r=1.
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   req_valid  in   NREQ         per-requester command valid
//   req_op     in   2*NREQ       op of requester i at [2i+1:2i]
//   req_mask   in   WIDTH*NREQ   mask of requester i at [WIDTH*i +: WIDTH]
//   req_ready  out  NREQ         one-hot accept pulse (IDLE only)
//   grant_id   out  clog2(NREQ)  requester being applied (valid while busy)
//   busy       out  1            high during APPLY
//   done       out  1            pulse in the cycle after q updates
//   q          out  WIDTH        SR bank state
// ---------------------------------------------------------------------------
module srff_bank_sched
  import srff_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [WIDTH*NREQ-1:0]     req_mask,
  output logic [NREQ-1:0]           req_ready,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          q
);

  localparam int IW = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [IW-1:0]    rrPtr_q, rrPtr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [IW-1:0]    id_q, id_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic             done_q, done_d;

  logic [NREQ-1:0]  winGrant;
  logic [IW-1:0]    winIdx;
  logic             anyValid;
  logic [WIDTH-1:0] tVec;

  rr_arb #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (winGrant),
    .idx_o   (winIdx),
    .any_o   (anyValid)
  );

  // Next-state and output logic. In IDLE the arbiter winner is accepted and
  // its command latched; in APPLY the latched command is converted to T
  // inputs. SET only toggles bits currently 0 and RESET only bits currently
  // 1, which is what keeps the cells free of the forbidden s=r=1 case.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    op_d      = op_q;
    mask_d    = mask_q;
    id_d      = id_q;
    bank_d    = bank_q;
    done_d    = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    grant_id  = '0;
    tVec      = '0;
    case (state_q)
      ST_IDLE: begin
        if (anyValid) begin
          req_ready = winGrant;
          op_d      = req_op[2*int'(winIdx) +: 2];
          mask_d    = req_mask[WIDTH*int'(winIdx) +: WIDTH];
          id_d      = winIdx;
          rrPtr_d   = (winIdx == IW'(NREQ - 1)) ? '0 : winIdx + 1'b1;
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        busy     = 1'b1;
        grant_id = id_q;
        case (op_q)
          OP_SET:    tVec = mask_q & ~bank_q;
          OP_RESET:  tVec = mask_q & bank_q;
          OP_TOGGLE: tVec = mask_q;
          default:   tVec = '0;
        endcase
        bank_d  = bank_q ^ tVec;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched command, round-robin pointer and the T-flip-flop bank.
  // Reset during APPLY discards the latched command and suppresses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rrPtr_q <= '0;
      op_q    <= OP_NOP;
      mask_q  <= '0;
      id_q    <= '0;
      bank_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  assign q    = bank_q;
  assign done = done_q;

endmodule
